// File: rtl/irom_pkg.sv
// Shared types and defaults for the Hack instruction memory and its loader.
package irom_pkg;

    localparam int DEFAULT_DATA_W = 16;
    localparam int DEFAULT_ADDR_W = 16;

    localparam logic [DEFAULT_DATA_W-1:0] DEFAULT_NOP_WORD = '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } load_state_e;

endpackage

// File: rtl/irom_loader.sv
// Load-burst controller: accepts a stream of words from a loader and turns it
// into write strobes for the instruction memory, with an exit cycle through DONE.
module irom_loader
    import irom_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic [ADDR_W-1:0] load_base,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_valid,
    input  logic              load_last,
    output logic              load_ready,
    output logic              load_busy,
    output logic              load_done,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata
);

    load_state_e       state_q, state_d;
    logic [ADDR_W-1:0] wptr_q, wptr_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            wptr_q  <= '0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
        end
    end

    // The write pointer wraps naturally at 2^ADDR_W.
    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        case (state_q)
            IDLE: begin
                if (load_start) begin
                    wptr_d  = load_base;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (load_valid) begin
                    wptr_d = wptr_q + ADDR_W'(1);
                    if (load_last) begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        load_ready = (state_q == LOAD);
        load_busy  = (state_q != IDLE);
        load_done  = (state_q == DONE);
        we         = rst_n && (state_q == LOAD) && load_valid;
        waddr      = wptr_q;
        wdata      = load_data;
    end

endmodule

// File: rtl/instr_rom.sv
// Registered-fetch instruction memory for the Hack CPU (one cycle fetch latency).
// Define IROM_LOAD_EN to build the in-system load port; otherwise the memory is read-only.
module instr_rom
    import irom_pkg::*;
#(
    parameter int                DATA_W   = DEFAULT_DATA_W,
    parameter int                ADDR_W   = DEFAULT_ADDR_W,
    parameter int                DEPTH    = 65536,
    parameter string             ROMFILE  = "ROM.hack",
    parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(DEFAULT_NOP_WORD)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] pc,
    input  logic              en,
    output logic [DATA_W-1:0] instruction,
    output logic              valid,
    output logic              oor,
    input  logic              load_start,
    input  logic [ADDR_W-1:0] load_base,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_valid,
    input  logic              load_last,
    output logic              load_ready,
    output logic              load_busy,
    output logic              load_done
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];

`ifdef IROM_LOAD_EN
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;

    irom_loader #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_loader (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_start (load_start),
        .load_base  (load_base),
        .load_data  (load_data),
        .load_valid (load_valid),
        .load_last  (load_last),
        .load_ready (load_ready),
        .load_busy  (load_busy),
        .load_done  (load_done),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata)
    );

    // Words aimed beyond the implemented depth are dropped.
    always @(posedge clk) begin
        if (we && (int'(waddr) < DEPTH)) begin
            mem[waddr[IDX_W-1:0]] <= wdata;
        end
    end
`else
    logic unused_load_inputs;
    assign unused_load_inputs = ^{load_start, load_base, load_data, load_valid, load_last};
    assign load_ready = 1'b0;
    assign load_busy  = 1'b0;
    assign load_done  = 1'b0;
`endif

    logic              in_range;
    logic              fetch_fire;
    logic              valid_q, valid_d;
    logic              oor_q, oor_d;
    logic              nop_q, nop_d;
    logic [DATA_W-1:0] rd_word_q;

    assign in_range   = (int'(pc) < DEPTH);
    assign fetch_fire = en && !load_busy;

    always_comb begin
        valid_d = valid_q;
        oor_d   = oor_q;
        nop_d   = nop_q;
        if (en) begin
            if (load_busy) begin
                valid_d = 1'b0;
            end else begin
                valid_d = 1'b1;
                oor_d   = !in_range;
                nop_d   = !in_range;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            oor_q   <= 1'b0;
            nop_q   <= 1'b1;
        end else begin
            valid_q <= valid_d;
            oor_q   <= oor_d;
            nop_q   <= nop_d;
        end
    end

    // Plain registered read without reset keeps the array mappable to block RAM;
    // nop_q masks it after reset and for out-of-range fetches.
    always_ff @(posedge clk) begin
        if (fetch_fire && in_range) begin
            rd_word_q <= mem[pc[IDX_W-1:0]];
        end
    end

    assign instruction = nop_q ? NOP_WORD : rd_word_q;
    assign valid       = valid_q;
    assign oor         = oor_q;

endmodule

// File: tb/tb_instr_rom.sv
// Directed bench for instr_rom with a 256-word image; exercises the load port
// when IROM_LOAD_EN is defined and checks it stays inert otherwise.
module tb_instr_rom;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] pc;
    logic        en;
    logic [15:0] instruction;
    logic        valid;
    logic        oor;
    logic        load_start;
    logic [15:0] load_base;
    logic [15:0] load_data;
    logic        load_valid;
    logic        load_last;
    logic        load_ready;
    logic        load_busy;
    logic        load_done;

    int tests_run = 0;
    int tests_failed = 0;
    int done_seen = 0;

    always #5 clk = ~clk;

    instr_rom #(
        .DATA_W   (16),
        .ADDR_W   (16),
        .DEPTH    (256),
        .ROMFILE  (""),
        .NOP_WORD (16'h0000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pc          (pc),
        .en          (en),
        .instruction (instruction),
        .valid       (valid),
        .oor         (oor),
        .load_start  (load_start),
        .load_base   (load_base),
        .load_data   (load_data),
        .load_valid  (load_valid),
        .load_last   (load_last),
        .load_ready  (load_ready),
        .load_busy   (load_busy),
        .load_done   (load_done)
    );

    typedef struct {
        logic        rst_n;
        logic        en;
        logic [15:0] pc;
        logic [15:0] exp_instr;
        logic        exp_valid;
        logic        exp_oor;
        string       name;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [15:0] img(input int i);
        logic [7:0] b;
        b = i[7:0];
        return {b, ~b};
    endfunction

    task automatic stepClk();
        @(posedge clk);
        #1;
        if (load_done === 1'b1) done_seen++;
    endtask

    task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic e, input logic [15:0] p);
        rst_n = r;
        en    = e;
        pc    = p;
        stepClk();
    endtask

    task automatic fetchCheck(input logic [15:0] p, input logic [15:0] exp_i, input logic exp_o, input string nm);
        applyStimulus(1'b1, 1'b1, p);
        checkOutput({nm, ".instr"}, 32'(instruction), 32'(exp_i));
        checkOutput({nm, ".valid"}, 32'(valid), 32'd1);
        checkOutput({nm, ".oor"}, 32'(oor), 32'(exp_o));
    endtask

    task automatic checkLoadFlags(input logic r, input logic b, input logic d, input string nm);
        checkOutput({nm, ".ready"}, 32'(load_ready), 32'(r));
        checkOutput({nm, ".busy"}, 32'(load_busy), 32'(b));
        checkOutput({nm, ".done"}, 32'(load_done), 32'(d));
    endtask

    initial begin
        for (int i = 0; i < 256; i++) dut.mem[i] = img(i);

        rst_n = 1'b0; en = 1'b0; pc = '0;
        load_start = 1'b0; load_base = '0; load_data = '0;
        load_valid = 1'b0; load_last = 1'b0;

        vecs.push_back('{1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, "reset0"});
        vecs.push_back('{1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, "reset1"});
        vecs.push_back('{1'b1, 1'b1, 16'h0000, img(0),   1'b1, 1'b0, "fetch0"});
        vecs.push_back('{1'b1, 1'b1, 16'h0005, img(5),   1'b1, 1'b0, "fetch5"});
        vecs.push_back('{1'b1, 1'b0, 16'h0009, img(5),   1'b1, 1'b0, "stall1"});
        vecs.push_back('{1'b1, 1'b0, 16'h0009, img(5),   1'b1, 1'b0, "stall2"});
        vecs.push_back('{1'b1, 1'b0, 16'h0009, img(5),   1'b1, 1'b0, "stall3"});
        vecs.push_back('{1'b1, 1'b1, 16'h0009, img(9),   1'b1, 1'b0, "fetch9"});
        vecs.push_back('{1'b1, 1'b1, 16'h0100, 16'h0000, 1'b1, 1'b1, "oor100"});
        vecs.push_back('{1'b1, 1'b0, 16'h00FF, 16'h0000, 1'b1, 1'b1, "oorhold"});
        vecs.push_back('{1'b1, 1'b1, 16'h00FF, img(255), 1'b1, 1'b0, "fetchFF"});
        vecs.push_back('{1'b1, 1'b1, 16'hFFFF, 16'h0000, 1'b1, 1'b1, "oorFFFF"});
        vecs.push_back('{1'b1, 1'b1, 16'h0080, img(128), 1'b1, 1'b0, "fetch80"});
        vecs.push_back('{1'b0, 1'b1, 16'h0080, 16'h0000, 1'b0, 1'b0, "reset2"});
        vecs.push_back('{1'b1, 1'b0, 16'h0003, 16'h0000, 1'b0, 1'b0, "idleAfterRst"});
        vecs.push_back('{1'b1, 1'b1, 16'h0003, img(3),   1'b1, 1'b0, "fetch3"});

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rst_n, vecs[i].en, vecs[i].pc);
            checkOutput({vecs[i].name, ".instr"}, 32'(instruction), 32'(vecs[i].exp_instr));
            checkOutput({vecs[i].name, ".valid"}, 32'(valid), 32'(vecs[i].exp_valid));
            checkOutput({vecs[i].name, ".oor"}, 32'(oor), 32'(vecs[i].exp_oor));
            checkLoadFlags(1'b0, 1'b0, 1'b0, vecs[i].name);
        end

`ifdef IROM_LOAD_EN
        // Burst of three words at 0x0010 with a two-cycle gap.
        done_seen = 0;
        en = 1'b1; pc = 16'h0020;
        load_start = 1'b1; load_base = 16'h0010;
        stepClk();
        load_start = 1'b0;
        checkLoadFlags(1'b1, 1'b1, 1'b0, "burstStart");
        load_valid = 1'b1; load_data = 16'hAAAA;
        stepClk();
        checkOutput("busyFetch.valid", 32'(valid), 32'd0);
        load_valid = 1'b0;
        stepClk();
        checkLoadFlags(1'b1, 1'b1, 1'b0, "gap1");
        stepClk();
        checkLoadFlags(1'b1, 1'b1, 1'b0, "gap2");
        load_valid = 1'b1; load_data = 16'hBBBB;
        stepClk();
        load_data = 16'hCCCC; load_last = 1'b1;
        stepClk();
        checkLoadFlags(1'b0, 1'b1, 1'b1, "burstDone");
        load_valid = 1'b0; load_last = 1'b0;
        stepClk();
        checkLoadFlags(1'b0, 1'b0, 1'b0, "burstIdle");
        checkOutput("doneFetch.valid", 32'(valid), 32'd0);
        checkOutput("burst.donePulses", 32'(done_seen), 32'd1);
        applyStimulus(1'b1, 1'b0, 16'h0000);
        fetchCheck(16'h0010, 16'hAAAA, 1'b0, "rd10");
        fetchCheck(16'h0011, 16'hBBBB, 1'b0, "rd11");
        fetchCheck(16'h0012, 16'hCCCC, 1'b0, "rd12");
        fetchCheck(16'h0013, img(19),  1'b0, "rd13");

        // Base 0xFFFF: first word is beyond DEPTH and dropped, second wraps to 0.
        done_seen = 0;
        load_start = 1'b1; load_base = 16'hFFFF;
        stepClk();
        load_start = 1'b0;
        load_valid = 1'b1; load_data = 16'h1111;
        stepClk();
        load_data = 16'h2222; load_last = 1'b1;
        stepClk();
        load_valid = 1'b0; load_last = 1'b0;
        stepClk();
        checkOutput("wrap.donePulses", 32'(done_seen), 32'd1);
        applyStimulus(1'b1, 1'b0, 16'h0000);
        fetchCheck(16'h0000, 16'h2222, 1'b0, "wrap0");
        fetchCheck(16'hFFFF, 16'h0000, 1'b1, "wrapFFFF");
        fetchCheck(16'h0001, img(1),   1'b0, "wrap1");

        // Reset in the middle of a burst keeps the word already written.
        load_start = 1'b1; load_base = 16'h0040;
        stepClk();
        load_start = 1'b0;
        load_valid = 1'b1; load_data = 16'h5555;
        stepClk();
        load_valid = 1'b0;
        checkLoadFlags(1'b1, 1'b1, 1'b0, "midBurst");
        applyStimulus(1'b0, 1'b0, 16'h0040);
        checkLoadFlags(1'b0, 1'b0, 1'b0, "midRst");
        checkOutput("midRst.valid", 32'(valid), 32'd0);
        applyStimulus(1'b1, 1'b0, 16'h0040);
        checkLoadFlags(1'b0, 1'b0, 1'b0, "postRst");
        fetchCheck(16'h0040, 16'h5555, 1'b0, "kept40");
        fetchCheck(16'h0041, img(65),  1'b0, "kept41");
`else
        // Load port must be inert in the read-only build.
        done_seen = 0;
        en = 1'b0;
        load_start = 1'b1; load_base = 16'h0010;
        load_valid = 1'b1; load_data = 16'h1234; load_last = 1'b1;
        for (int i = 0; i < 4; i++) begin
            stepClk();
            checkLoadFlags(1'b0, 1'b0, 1'b0, "roLoad");
        end
        load_start = 1'b0; load_valid = 1'b0; load_last = 1'b0;
        checkOutput("ro.donePulses", 32'(done_seen), 32'd0);
        fetchCheck(16'h0010, img(16), 1'b0, "ro10");
        fetchCheck(16'h0011, img(17), 1'b0, "ro11");
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
